// File: rtl/isqrt_arb_pkg.sv
// Shared types and limits for the round-robin isqrt arbiter.
package isqrt_arb_pkg;

  localparam int N_REQ_MAX = 8;

  typedef logic [31:0] isqrt_arg_t;
  typedef logic [15:0] isqrt_res_t;

  // Owner of one in-flight isqrt operation.
  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } isqrt_tag_t;

endpackage

// File: rtl/isqrt_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N_REQ. Returns one-hot grant, its index and an any flag.
module isqrt_rr_pick
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // NOTE: blocking assignments here so 'any' set at step k is seen by step k+1 of the same scan.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end sharing one pipelined isqrt between N_REQ requesters.
// A tag pipeline follows each op through the isqrt so the returned root can
// be steered back to its owner. Define ISQRT_ARB_STATS_EN to add per-requester
// 16-bit grant counters on port grant_cnt.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ISQRT_LAT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*32-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic                 sq_x_vld,
  output logic [31:0]          sq_x,
  input  logic                 sq_y_vld,
  input  logic [15:0]          sq_y,
  output logic [N_REQ-1:0]     rsp_vld,
  output logic [15:0]          rsp_y,
  output logic                 err_sync
`ifdef ISQRT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             hs;
  isqrt_arg_t       sel_x;

  // Stage 0 lines up with sq_x_vld; stage k is the op k cycles into the
  // isqrt, so stage ISQRT_LAT lines up with sq_y_vld.
  logic [ISQRT_LAT:0] tag_vld;
  logic [2:0]         tag_id [ISQRT_LAT+1];
  isqrt_tag_t         tag_last;
  logic [N_REQ-1:0]   last_onehot;

  isqrt_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grants are forced low while reset is asserted.
  assign req_rdy = rst ? pick_gnt : '0;
  assign hs      = rst & pick_any;

  // Operand of the granted requester.
  always_comb begin
    sel_x = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_gnt[i]) sel_x = req_x[32*i +: 32];
  end

  assign tag_last = '{vld: tag_vld[ISQRT_LAT], id: tag_id[ISQRT_LAT]};

  // Decode the owner of the op leaving the isqrt.
  always_comb begin
    last_onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      if (tag_last.id == 3'(i)) last_onehot[i] = 1'b1;
  end

  // Issue stage, round-robin pointer and tag valid shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      sq_x_vld <= 1'b0;
      sq_x     <= '0;
      tag_vld  <= '0;
    end else begin
      sq_x_vld <= hs;
      tag_vld  <= {tag_vld[ISQRT_LAT-1:0], hs};
      if (hs) begin
        sq_x   <= sel_x;
        rr_ptr <= (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // Tag id shift register, moved only alongside a valid entry.
  // NOTE: ids carry no reset; they are only ever read qualified by tag_vld, which is reset.
  always_ff @(posedge clk) begin
    if (hs) tag_id[0] <= 3'(pick_idx);
    for (int k = 1; k <= ISQRT_LAT; k++)
      if (tag_vld[k-1]) tag_id[k] <= tag_id[k-1];
  end

  // Response stage and sticky pipeline-sync error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld  <= '0;
      rsp_y    <= '0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= err_sync | (sq_y_vld != tag_last.vld);
      if (sq_y_vld && tag_last.vld) begin
        rsp_vld <= last_onehot;
        rsp_y   <= sq_y;
      end else begin
        rsp_vld <= '0;
      end
    end
  end

`ifdef ISQRT_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  // Per-requester grant counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (hs && pick_gnt[i]) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[16*g +: 16] = cnt[g];
  end
`endif

endmodule
